// File: rtl/foc_loop_sequencer_pkg.sv
// Shared types and defaults for the FOC loop sequencer: FSM states, datapath
// stage identifiers and the default per-stage watchdog limit.
package foc_seq_pkg;

  localparam int DEFAULT_TIMEOUT = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADC,
    S_TF,
    S_PI,
    S_MOD,
    S_COMMIT,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    STAGE_ADC = 2'd0,
    STAGE_TF  = 2'd1,
    STAGE_PI  = 2'd2,
    STAGE_MOD = 2'd3
  } stage_e;

  // ADC through COMMIT form one control iteration in flight.
  function automatic logic is_busy(input state_e s);
    return (s inside {S_ADC, S_TF, S_PI, S_MOD, S_COMMIT});
  endfunction

endpackage

// File: rtl/foc_loop_sequencer_watchdog.sv
// Per-stage wait timer: cleared on a stage start pulse, counts wait cycles and
// flags the cycle in which the TIMEOUT-th wait cycle is reached.
module seq_watchdog
  import foc_seq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of wait cycles already spent, so this is the last allowed one.
  assign expired = enable && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/foc_loop_sequencer.sv
// Walks one FOC iteration (ADC, transform, PI, SVPWM, commit) per accepted tick,
// with stage timeouts, dropped-tick counting and iteration latency capture.
module foc_loop_sequencer
  import foc_seq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int LAT_W   = 16,
  parameter int OVR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             adc_done,
  input  logic             tf_done,
  input  logic             pi_done,
  input  logic             mod_done,
  input  logic             fault_clr,
  output logic             adc_start,
  output logic             tf_start,
  output logic             pi_start,
  output logic             mod_start,
  output logic             pwm_load,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_stage,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic [LAT_W-1:0] last_latency
);

  state_e           state_q, state_d;
  logic             adc_start_q, adc_start_d;
  logic             tf_start_q, tf_start_d;
  logic             pi_start_q, pi_start_d;
  logic             mod_start_q, mod_start_d;
  logic             pwm_load_q, pwm_load_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  stage_e           fault_stage_q, fault_stage_d;
  logic [OVR_W-1:0] overrun_q, overrun_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] last_lat_q, last_lat_d;

  logic             cur_done;
  stage_e           cur_stage;
  logic             stage_start;
  logic             wd_enable;
  logic             wd_expired;
  logic             done_ok;
  logic [LAT_W-1:0] lat_next;

  // A done only counts once the stage's own start pulse has gone by.
  assign stage_start = adc_start_q | tf_start_q | pi_start_q | mod_start_q;
  assign wd_enable   = (state_q inside {S_ADC, S_TF, S_PI, S_MOD}) && !stage_start;
  assign done_ok     = cur_done && wd_enable;
  assign lat_next    = (lat_q == '1) ? lat_q : lat_q + 1'b1;

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (stage_start),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    cur_done  = 1'b0;
    cur_stage = STAGE_ADC;
    case (state_q)
      S_ADC: begin cur_done = adc_done; cur_stage = STAGE_ADC; end
      S_TF:  begin cur_done = tf_done;  cur_stage = STAGE_TF;  end
      S_PI:  begin cur_done = pi_done;  cur_stage = STAGE_PI;  end
      S_MOD: begin cur_done = mod_done; cur_stage = STAGE_MOD; end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    adc_start_d   = 1'b0;
    tf_start_d    = 1'b0;
    pi_start_d    = 1'b0;
    mod_start_d   = 1'b0;
    pwm_load_d    = 1'b0;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;
    overrun_d     = overrun_q;
    lat_d         = lat_q;
    last_lat_d    = last_lat_q;

    case (state_q)
      S_IDLE: begin
        if (tick && en) begin
          state_d     = S_ADC;
          adc_start_d = 1'b1;
          lat_d       = LAT_W'(1);
        end
      end
      S_ADC, S_TF, S_PI, S_MOD: begin
        lat_d = lat_next;
        if (done_ok) begin
          case (state_q)
            S_ADC:   begin state_d = S_TF;     tf_start_d  = 1'b1; end
            S_TF:    begin state_d = S_PI;     pi_start_d  = 1'b1; end
            S_PI:    begin state_d = S_MOD;    mod_start_d = 1'b1; end
            default: begin state_d = S_COMMIT; pwm_load_d  = 1'b1; end
          endcase
        end else if (wd_expired) begin
          state_d       = S_FAULT;
          fault_d       = 1'b1;
          fault_stage_d = cur_stage;
        end
      end
      S_COMMIT: begin
        state_d    = S_IDLE;
        last_lat_d = lat_q;
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ticks in FAULT or with en low are simply ignored, not counted.
    if (tick && en && is_busy(state_q) && (overrun_q != '1)) begin
      overrun_d = overrun_q + 1'b1;
    end

    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      adc_start_q   <= 1'b0;
      tf_start_q    <= 1'b0;
      pi_start_q    <= 1'b0;
      mod_start_q   <= 1'b0;
      pwm_load_q    <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= STAGE_ADC;
      overrun_q     <= '0;
      lat_q         <= '0;
      last_lat_q    <= '0;
    end else begin
      state_q       <= state_d;
      adc_start_q   <= adc_start_d;
      tf_start_q    <= tf_start_d;
      pi_start_q    <= pi_start_d;
      mod_start_q   <= mod_start_d;
      pwm_load_q    <= pwm_load_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
      overrun_q     <= overrun_d;
      lat_q         <= lat_d;
      last_lat_q    <= last_lat_d;
    end
  end

  assign adc_start    = adc_start_q;
  assign tf_start     = tf_start_q;
  assign pi_start     = pi_start_q;
  assign mod_start    = mod_start_q;
  assign pwm_load     = pwm_load_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign fault_stage  = fault_stage_q;
  assign overrun_cnt  = overrun_q;
  assign last_latency = last_lat_q;

endmodule

// File: tb/tb_foc_loop_sequencer.sv
// Scoreboard bench for foc_loop_sequencer: a cycle script is planned from an
// iteration-level timing model, then replayed while a monitor checks the DUT.
module tb_foc_loop_sequencer;

  localparam int T       = 60;
  localparam int LW      = 6;
  localparam int OW      = 3;
  localparam int LAT_MAX = (1 << LW) - 1;
  localparam int OVR_MAX = (1 << OW) - 1;
  localparam int MAXC    = 20000;

  logic          clk;
  logic          rst;
  logic          en;
  logic          tick;
  logic          adc_done, tf_done, pi_done, mod_done;
  logic          fault_clr;
  logic          adc_start, tf_start, pi_start, mod_start;
  logic          pwm_load;
  logic          busy;
  logic          fault;
  logic [1:0]    fault_stage;
  logic [OW-1:0] overrun_cnt;
  logic [LW-1:0] last_latency;

  foc_loop_sequencer #(
    .TIMEOUT(T),
    .LAT_W  (LW),
    .OVR_W  (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .tick        (tick),
    .adc_done    (adc_done),
    .tf_done     (tf_done),
    .pi_done     (pi_done),
    .mod_done    (mod_done),
    .fault_clr   (fault_clr),
    .adc_start   (adc_start),
    .tf_start    (tf_start),
    .pi_start    (pi_start),
    .mod_start   (mod_start),
    .pwm_load    (pwm_load),
    .busy        (busy),
    .fault       (fault),
    .fault_stage (fault_stage),
    .overrun_cnt (overrun_cnt),
    .last_latency(last_latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event kinds 0..3 = stage start pulses, 4 = pwm_load, 5 = fault rising (val = stage).
  typedef struct {int cyc; int kind; int val;} ev_t;
  typedef struct {int cyc; int ovr; int lat; int flt; int fstg; int bsy;} chk_t;

  ev_t      ev_q[$];
  chk_t     chk_q[$];
  bit       tick_s [MAXC];
  bit       en_s   [MAXC];
  bit       clr_s  [MAXC];
  bit       rst_s  [MAXC];
  bit [3:0] done_s [MAXC];

  int m_ovr, m_lat, m_fstg;
  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = -1;
  bit prev_fault = 1'b0;
  bit finished   = 1'b0;
  int t, last, sel;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void push_ev(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    ev_q.push_back(e);
  endfunction

  function automatic void push_chk(input int c, input int o, input int l,
                                   input int f, input int fs, input int b);
    chk_t k;
    k.cyc = c; k.ovr = o; k.lat = l; k.flt = f; k.fstg = fs; k.bsy = b;
    chk_q.push_back(k);
  endfunction

  // Plans one iteration ticked at cycle tt; a stage delay above T makes it time out.
  task automatic applyStimulus(input int tt, input int d0, input int d1, input int d2,
                               input int d3, input int tick_pct, input bit en_drop,
                               input bit commit_tick, input int clr_wait, output int nxt);
    int d[4];
    int s, fs, fc, busy_end, cnt, j;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    s  = tt + 1;
    fs = -1;
    fc = 0;
    tick_s[tt] = 1'b1;
    en_s[tt]   = 1'b1;
    push_chk(tt + 1, m_ovr, m_lat, 0, m_fstg, 1);
    for (int i = 0; i < 4; i++) begin
      push_ev(s, i, 0);
      if (d[i] <= T) begin
        done_s[s + d[i]][i] = 1'b1;
        if ($urandom_range(2) == 0) done_s[s][i] = 1'b1;
        if (d[i] > 1 && $urandom_range(1) == 1) begin
          j = (i + 1 + int'($urandom_range(2))) % 4;
          done_s[s + 1 + int'($urandom_range(d[i] - 2))][j] = 1'b1;
        end
        s = s + d[i] + 1;
      end else begin
        fs = i;
        fc = s + T + 1;
        done_s[fc][i] = 1'b1;
        break;
      end
    end
    if (fs < 0) begin
      push_ev(s, 4, 0);
      busy_end = s;
    end else begin
      push_ev(fc, 5, fs);
      busy_end = fc - 1;
    end
    cnt = 0;
    for (int c = tt + 1; c <= busy_end; c++) begin
      if (en_drop) en_s[c] = 1'($urandom_range(1));
      if (int'($urandom_range(99)) < tick_pct) tick_s[c] = 1'b1;
      if (commit_tick && fs < 0 && c == busy_end) tick_s[c] = 1'b1;
      if (tick_s[c] && en_s[c]) cnt++;
    end
    m_ovr = imin(m_ovr + cnt, OVR_MAX);
    if (fs < 0) begin
      m_lat = imin(s - tt, LAT_MAX);
      push_chk(s + 1, m_ovr, m_lat, 0, m_fstg, 0);
      nxt = s + 1;
    end else begin
      m_fstg = fs;
      for (int c = fc; c <= fc + clr_wait; c++)
        if ($urandom_range(2) == 0) tick_s[c] = 1'b1;
      clr_s[fc + clr_wait] = 1'b1;
      push_chk(fc, m_ovr, m_lat, 1, fs, 0);
      push_chk(fc + clr_wait + 1, m_ovr, m_lat, 0, fs, 0);
      nxt = fc + clr_wait + 1;
    end
  endtask

  task automatic applyGated(input int tt, output int nxt);
    tick_s[tt] = 1'b1;
    en_s[tt]   = 1'b0;
    push_chk(tt + 1, m_ovr, m_lat, 0, m_fstg, 0);
    nxt = tt + 1;
  endtask

  // Reset lands in the MOD wait; the mod_done arrives one cycle too late.
  task automatic applyMidReset(input int tt, output int nxt);
    int r;
    tick_s[tt] = 1'b1;
    en_s[tt]   = 1'b1;
    done_s[tt + 2][0] = 1'b1;
    done_s[tt + 4][1] = 1'b1;
    done_s[tt + 6][2] = 1'b1;
    tick_s[tt + 3]    = 1'b1;
    for (int i = 0; i < 4; i++) push_ev(tt + 1 + 2 * i, i, 0);
    r = tt + 11;
    rst_s[r] = 1'b1;
    done_s[r + 1][3] = 1'b1;
    m_ovr = 0; m_lat = 0; m_fstg = 0;
    push_chk(r + 1, 0, 0, 0, 0, 0);
    nxt = r + 2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, cur, act, exp);
    end
  endtask

  task automatic checkEvent(input int k);
    ev_t e;
    n_cmp++;
    if (ev_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL event @cycle %0d: got kind %0d, expected none", cur, k);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != k || e.cyc != cur || (k == 5 && int'(fault_stage) != e.val)) begin
        n_fail++;
        $display("[TB] FAIL event: got kind %0d @cycle %0d stage %0d, expected kind %0d @cycle %0d stage %0d",
                 k, cur, fault_stage, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, sampled on the falling edge.
  always @(negedge clk) begin
    bit [5:0] obs;
    chk_t     c;
    if (cur >= 0 && !finished) begin
      obs = {(fault === 1'b1) && !prev_fault, pwm_load === 1'b1, mod_start === 1'b1,
             pi_start === 1'b1, tf_start === 1'b1, adc_start === 1'b1};
      prev_fault = (fault === 1'b1);
      for (int k = 0; k < 6; k++)
        if (obs[k]) checkEvent(k);
      while (chk_q.size() > 0 && chk_q[0].cyc == cur) begin
        c = chk_q.pop_front();
        checkOutput("overrun_cnt", 32'(overrun_cnt), c.ovr);
        checkOutput("last_latency", 32'(last_latency), c.lat);
        checkOutput("fault", 32'(fault), c.flt);
        checkOutput("fault_stage", 32'(fault_stage), c.fstg);
        checkOutput("busy", 32'(busy), c.bsy);
      end
    end
  end

  initial begin
    int d[4];
    int r;
    rst = 1'b1; en = 1'b0; tick = 1'b0; fault_clr = 1'b0;
    adc_done = 1'b0; tf_done = 1'b0; pi_done = 1'b0; mod_done = 1'b0;
    for (int c = 0; c < MAXC; c++) en_s[c] = 1'b1;
    rst_s[0] = 1'b1; rst_s[1] = 1'b1; rst_s[2] = 1'b1;
    m_ovr = 0; m_lat = 0; m_fstg = 0;
    push_chk(3, 0, 0, 0, 0, 0);
    t = 3;

    applyStimulus(t, 1, 1, 1, 1, 0, 1'b0, 1'b0, 0, t);
    applyStimulus(t, 50, 1, 1, 1, 0, 1'b0, 1'b0, 0, t);
    t += 2;
    applyStimulus(t, 1, 1, T + 1, 1, 0, 1'b0, 1'b0, 3, t);
    applyStimulus(t, 1, 1, 1, 1, 0, 1'b0, 1'b0, 0, t);
    applyStimulus(t, 3, 4, 2, 3, 40, 1'b0, 1'b1, 0, t);
    applyGated(t, t);
    applyStimulus(t, 2, 2, 2, 2, 30, 1'b1, 1'b0, 0, t);
    applyMidReset(t, t);
    applyStimulus(t, 1, 1, 1, 1, 0, 1'b0, 1'b0, 0, t);
    applyStimulus(t, T, 1, 1, 1, 0, 1'b0, 1'b0, 0, t);
    applyStimulus(t, 1, 1, 1, T + 1, 10, 1'b0, 1'b0, 0, t);

    for (int it = 0; it < 80 && t < MAXC - 400; it++) begin
      sel = int'($urandom_range(19));
      if (sel == 0) begin
        applyGated(t, t);
      end else if (sel == 1) begin
        applyMidReset(t, t);
      end else begin
        for (int i = 0; i < 4; i++) begin
          r = int'($urandom_range(15));
          if (r == 0)      d[i] = T;
          else if (r == 1) d[i] = ($urandom_range(3) == 0) ? T + 1 : 1;
          else if (r < 4)  d[i] = 1 + int'($urandom_range(T - 1));
          else             d[i] = 1 + int'($urandom_range(5));
        end
        applyStimulus(t, d[0], d[1], d[2], d[3], int'($urandom_range(29)),
                      1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0),
                      int'($urandom_range(3)), t);
      end
      t += int'($urandom_range(2));
    end
    last = t + 5;

    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      cur       = c;
      rst       = rst_s[c];
      tick      = tick_s[c];
      en        = en_s[c];
      fault_clr = clr_s[c];
      {mod_done, pi_done, tf_done, adc_done} = done_s[c];
    end
    @(posedge clk);
    #1;
    finished = 1'b1;

    n_cmp++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_events: got %0d outstanding, expected 0", ev_q.size());
    end
    n_cmp++;
    if (chk_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_checks: got %0d outstanding, expected 0", chk_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
